// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker for the stream produced by the shift-cell
// LFSR chain. It fills a local shift register from the stream, checks that
// the stream follows the LFSR rule for LOCK_COUNT bits in a row, and then
// locks. Once locked it runs its own copy of the LFSR and counts bit errors.
//
// Ports:
//   clk        rising-edge clock
//   areset_n   asynchronous active-low reset
//   bit_valid  bit_in is sampled this cycle
//   bit_in     received serial bit
//   err_clr    synchronous clear of err_count (clear wins over an increment)
//   locked     checker is in LOCKED
//   bit_err    one-cycle pulse per mispredicted bit while LOCKED
//   err_count  saturating count of mispredicted bits while LOCKED
//   state      00 SEARCH, 01 VERIFY, 10 LOCKED
//
// Build option: define PRBS_CHECKER_ERRCNT_EN to build the error counter.
// Without it, err_count is tied to 0 and err_clr is ignored.
module prbs_checker #(
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  TAPS       = 'hB8,
    parameter int                LOCK_COUNT = 4,
    parameter int                LOSS_COUNT = 3,
    parameter int                ERR_W      = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t            st_q, st_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [7:0]        match_q, match_d;
    logic [7:0]        miss_q, miss_d;
    logic              locked_q;
    logic              bit_err_q, bit_err_d;
    logic              err_inc;
    logic              pred;
    logic              vmiss;

    assign pred  = ^(r_q & TAPS);
    // An all-zero register predicts 0 forever; treating it as a miss keeps
    // a dead (all-zero) line from ever looking like a valid PRBS.
    assign vmiss = (bit_in != pred) || (r_q == '0);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            st_q      <= SEARCH;
            r_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            st_q      <= st_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked_q  <= (st_d == LOCKED);
            bit_err_q <= bit_err_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        r_d       = r_q;
        fill_d    = fill_q;
        match_d   = match_q;
        miss_d    = miss_q;
        bit_err_d = 1'b0;
        err_inc   = 1'b0;
        if (bit_valid) begin
            case (st_q)
                SEARCH: begin
                    r_d    = {r_q[WIDTH-2:0], bit_in};
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        st_d    = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    // Shift the received bit so the register re-aligns itself
                    // to the incoming sequence after any slip.
                    r_d = {r_q[WIDTH-2:0], bit_in};
                    if (vmiss) begin
                        match_d = '0;
                    end else if (match_q == 8'(LOCK_COUNT - 1)) begin
                        st_d   = LOCKED;
                        miss_d = '0;
                    end else begin
                        match_d = match_q + 8'd1;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction: a corrupted bit never enters
                    // the register, so it costs exactly one error.
                    r_d = {r_q[WIDTH-2:0], pred};
                    if (bit_in != pred) begin
                        bit_err_d = 1'b1;
                        err_inc   = 1'b1;
                        if (miss_q == 8'(LOSS_COUNT - 1)) begin
                            st_d   = SEARCH;
                            fill_d = '0;
                        end else begin
                            miss_d = miss_q + 8'd1;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    st_d   = SEARCH;
                    fill_d = '0;
                end
            endcase
        end
    end

`ifdef PRBS_CHECKER_ERRCNT_EN
    logic [ERR_W-1:0] err_q;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            err_q <= '0;
        end else if (err_clr) begin
            err_q <= '0;
        end else if (err_inc && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_count = err_q;
`else
    logic unused_errcnt;

    assign unused_errcnt = err_clr ^ err_inc;
    assign err_count     = '0;
`endif

    assign locked  = locked_q;
    assign bit_err = bit_err_q;
    assign state   = st_q;

endmodule
